// File: rtl/capture_pkg.sv
// Shared types, default sizing and geometry helpers for the IQ capture buffer.
package capture_pkg;

    localparam int unsigned NCH_DEF      = 2;
    localparam int unsigned SAMPLE_W_DEF = 1;
    localparam int unsigned WORD_W_DEF   = 36;
    localparam int unsigned DEPTH_DEF    = 512;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    function automatic int unsigned spw(input int unsigned word_w, input int unsigned sample_w);
        return word_w / sample_w;
    endfunction

    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port RAM bank: one write port, one registered read port (old data on collision).
module capture_ram
    import capture_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned WORD_W = WORD_W_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  logic [WORD_W-1:0]          i_wdata,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output logic [WORD_W-1:0]          o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Only the output register is reset; the array itself has no reset so it maps onto block RAM.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/iq_capture_buf.sv
// GNSS front-end capture buffer: synchronises the ADC clock, packs NCH sample streams
// into RAM words and stores them single-shot or as a ring, with an independent read port.
module iq_capture_buf
    import capture_pkg::*;
#(
    parameter int unsigned NCH      = NCH_DEF,
    parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
    parameter int unsigned WORD_W   = WORD_W_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        adc_clk,
    input  logic [NCH*SAMPLE_W-1:0]     adc_data,
    input  logic                        start,
    input  logic                        cont,
    input  logic [$clog2(DEPTH):0]      len,
    input  logic                        stop,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(DEPTH)-1:0]    wr_ptr,
    output logic                        wrapped,
    input  logic [$clog2(DEPTH)-1:0]    rd_addr,
    output logic [NCH*WORD_W-1:0]       rd_data
);

    localparam int unsigned SPW = spw(WORD_W, SAMPLE_W);
    localparam int unsigned AW  = addr_w(DEPTH);
    localparam int unsigned KW  = (SPW > 1) ? $clog2(SPW) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(SPW - 1);

    logic                       r_s0, r_s1, r_s2;
    logic [NCH*SAMPLE_W-1:0]    r_d0, r_d1;
    cap_state_t                 r_state;
    logic                       r_cont;
    logic [AW:0]                r_len;
    logic [KW-1:0]              r_k;
    logic [NCH*WORD_W-1:0]      r_pack;
    logic                       r_we;
    logic [AW-1:0]              r_wr_ptr;
    logic [AW:0]                r_wcnt;
    logic                       r_wrapped;

    logic                       w_ev;
    logic                       w_active;
    logic                       w_last_word;
    logic [NCH*WORD_W-1:0]      w_rdata;

    assign w_ev        = r_s1 & ~r_s2;
    assign w_active    = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
    assign w_last_word = r_we && !r_cont && ((r_wcnt + (AW+1)'(1)) == r_len);

    // Data takes one flop less than the clock so d1 lines up with the detected rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_d0 <= '0;
            r_d1 <= '0;
        end else begin
            r_s0 <= adc_clk;
            r_s1 <= r_s0;
            r_s2 <= r_s1;
            r_d0 <= adc_data;
            r_d1 <= r_d0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cont    <= 1'b0;
            r_len     <= '0;
            r_k       <= '0;
            r_we      <= 1'b0;
            r_wr_ptr  <= '0;
            r_wcnt    <= '0;
            r_wrapped <= 1'b0;
        end else begin
            r_we <= 1'b0;
            // A completed word is committed even if stop arrives in its write cycle.
            if (r_we) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_wcnt   <= r_wcnt + 1'b1;
                if (r_cont && (r_wr_ptr == '1)) begin
                    r_wrapped <= 1'b1;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_ARMED;
                        r_cont    <= cont;
                        r_len     <= len;
                        r_k       <= '0;
                        r_wr_ptr  <= '0;
                        r_wcnt    <= '0;
                        r_wrapped <= 1'b0;
                    end
                end
                ST_ARMED, ST_CAPTURE: begin
                    if (stop || w_last_word) begin
                        r_state <= ST_DONE;
                    end else if (w_ev) begin
                        r_state <= ST_CAPTURE;
                        if (r_k == K_LAST) begin
                            r_k  <= '0;
                            r_we <= 1'b1;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pack <= '0;
        end else if (w_ev && w_active && !stop && !w_last_word) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                r_pack[c*WORD_W + int'(r_k)*SAMPLE_W +: SAMPLE_W] <= r_d1[c*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_bank
        capture_ram #(
            .DEPTH  (DEPTH),
            .WORD_W (WORD_W)
        ) u_ram (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_we    (r_we),
            .i_waddr (r_wr_ptr),
            .i_wdata (r_pack[c*WORD_W +: WORD_W]),
            .i_raddr (rd_addr),
            .o_rdata (w_rdata[c*WORD_W +: WORD_W])
        );
    end

    assign busy    = w_active;
    assign done    = (r_state == ST_DONE);
    assign wr_ptr  = r_wr_ptr;
    assign wrapped = r_wrapped;
    assign rd_data = w_rdata;

endmodule

// File: tb/tb_iq_capture_buf.sv
// Randomised self-checking bench for iq_capture_buf at default parameters.
module tb_iq_capture_buf;

    localparam int unsigned NCH   = 2;
    localparam int unsigned SW    = 1;
    localparam int unsigned WW    = 36;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = 9;

    logic            clk = 1'b0;
    logic            rst;
    logic            adc_clk;
    logic [1:0]      adc_data;
    logic            start;
    logic            cont;
    logic [AW:0]     len;
    logic            stop;
    logic            busy;
    logic            done;
    logic [AW-1:0]   wr_ptr;
    logic            wrapped;
    logic [AW-1:0]   rd_addr;
    logic [2*WW-1:0] rd_data;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    iq_capture_buf #(
        .NCH      (NCH),
        .SAMPLE_W (SW),
        .WORD_W   (WW),
        .DEPTH    (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .adc_clk  (adc_clk),
        .adc_data (adc_data),
        .start    (start),
        .cont     (cont),
        .len      (len),
        .stop     (stop),
        .busy     (busy),
        .done     (done),
        .wr_ptr   (wr_ptr),
        .wrapped  (wrapped),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    // Reference model: expected bank contents and capture bookkeeping
    logic [WW-1:0] mm0 [DEPTH];
    logic [WW-1:0] mm1 [DEPTH];
    bit            m_active;
    bit            m_cont;
    int unsigned   m_len, m_words, m_ptr, m_k;
    logic [WW-1:0] m_acc0, m_acc1;

    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            done_cnt++;
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL done_busy: busy=%b required 0 while done is high", busy);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks start and end on a falling clk edge.
    task automatic feed(input logic [1:0] s, input int unsigned h);
        adc_data = s;
        adc_clk  = 1'b0;
        repeat (h) @(negedge clk);
        adc_clk = 1'b1;
        repeat (h) @(negedge clk);
        if (m_active) begin
            m_acc0[m_k] = s[0];
            m_acc1[m_k] = s[1];
            m_k++;
            if (m_k == WW) begin
                mm0[m_ptr] = m_acc0;
                mm1[m_ptr] = m_acc1;
                m_ptr   = (m_ptr + 1) % DEPTH;
                m_words++;
                m_k = 0;
                if (!m_cont && m_words == m_len) m_active = 0;
            end
        end
    endtask

    task automatic do_start(input bit c, input int unsigned l);
        start = 1'b1;
        cont  = c;
        len   = (AW+1)'(l);
        @(negedge clk);
        start    = 1'b0;
        m_active = 1;
        m_cont   = c;
        m_len    = l;
        m_words  = 0;
        m_ptr    = 0;
        m_k      = 0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(negedge clk);
        stop     = 1'b0;
        m_active = 0;
    endtask

    task automatic settle();
        adc_clk = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic wait_done(input int target, input string name);
        for (int i = 0; i < 40; i++) begin
            if (done_cnt >= target) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt !== target) begin
            errors++;
            $display("FAIL %s_done_count: got %0d pulses total, required %0d", name, done_cnt, target);
        end
    endtask

    task automatic check_word(input int unsigned a, input string name);
        rd_addr = AW'(a);
        @(negedge clk);
        checks++;
        if (rd_data !== {mm1[a], mm0[a]}) begin
            errors++;
            $display("FAIL %s_word[%0d]: got %h required %h", name, a, rd_data, {mm1[a], mm0[a]});
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; adc_clk = 1'b0; adc_data = '0; start = 1'b0; cont = 1'b0;
        len = '0; stop = 1'b0; rd_addr = '0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, wr_ptr, wrapped} !== '0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b wr_ptr=%0d wrapped=%b rd_data=%h required all 0",
                     busy, done, wr_ptr, wrapped, rd_data);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || wr_ptr !== '0) begin
            errors++;
            $display("FAIL reset_release: busy=%b wr_ptr=%0d required 0/0", busy, wr_ptr);
        end
    endtask

    task automatic test_single_shot();
        int base = done_cnt;
        do_start(0, 4);
        checks++;
        if (busy !== 1'b1 || wr_ptr !== '0) begin
            errors++;
            $display("FAIL single_armed: busy=%b wr_ptr=%0d required 1/0", busy, wr_ptr);
        end
        for (int i = 0; i < 4 * WW; i++) feed({1'b1, (i % 2 == 0) ? 1'b1 : 1'b0}, 5);
        wait_done(base + 1, "single");
        checks++;
        if (wr_ptr !== AW'(4) || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_wr_ptr: wr_ptr=%0d busy=%b required 4/0", wr_ptr, busy);
        end
        for (int a = 0; a < 4; a++) begin
            rd_addr = AW'(a);
            @(negedge clk);
            checks++;
            if (rd_data !== {36'hFFFFFFFFF, 36'h555555555}) begin
                errors++;
                $display("FAIL single_word[%0d]: got %h required %h", a, rd_data, {36'hFFFFFFFFF, 36'h555555555});
            end
        end
    endtask

    task automatic test_readback();
        int base = done_cnt;
        do_start(0, 8);
        for (int i = 0; i < 8 * WW; i++) feed(2'($urandom_range(3, 0)), 5);
        wait_done(base + 1, "readback");
        checks++;
        if (wr_ptr !== AW'(8)) begin
            errors++;
            $display("FAIL readback_wr_ptr: got %0d required 8", wr_ptr);
        end
        rd_addr = '0;
        @(negedge clk);
        for (int i = 1; i <= 8; i++) begin
            rd_addr = AW'(i % 8);
            #1;
            checks++;
            if (rd_data !== {mm1[i-1], mm0[i-1]}) begin
                errors++;
                $display("FAIL readback_sweep[%0d]: got %h required %h", i - 1, rd_data, {mm1[i-1], mm0[i-1]});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ring();
        int base = done_cnt;
        do_start(1, 0);
        for (int w = 0; w < 515; w++) begin
            for (int j = 0; j < WW; j++) feed(2'($urandom_range(3, 0)), 2);
            if (w == 510 || w == 511) begin
                settle();
                checks++;
                if (wrapped !== ((w == 511) ? 1'b1 : 1'b0) || wr_ptr !== AW'(m_ptr)) begin
                    errors++;
                    $display("FAIL ring_wrap_at_%0d: wrapped=%b wr_ptr=%0d required %b/%0d",
                             w, wrapped, wr_ptr, (w == 511), m_ptr);
                end
            end
        end
        settle();
        do_stop();
        wait_done(base + 1, "ring");
        checks++;
        if (wrapped !== 1'b1 || wr_ptr !== AW'(3)) begin
            errors++;
            $display("FAIL ring_final: wrapped=%b wr_ptr=%0d required 1/3", wrapped, wr_ptr);
        end
        check_word(2, "ring");
        check_word(3, "ring");
        check_word(0, "ring");
        check_word(511, "ring");
    endtask

    task automatic test_stop();
        logic [2*WW-1:0] prev0 = {mm1[0], mm0[0]};
        int base = done_cnt;
        do_start(0, 4);
        checks++;
        if (wrapped !== 1'b0) begin
            errors++;
            $display("FAIL stop_wrap_clear: wrapped=%b required 0 after start", wrapped);
        end
        for (int i = 0; i < 20; i++) feed(2'($urandom_range(3, 0)), 5);
        do_stop();
        wait_done(base + 1, "stop_partial");
        rd_addr = '0;
        @(negedge clk);
        checks++;
        if (wr_ptr !== '0 || rd_data !== prev0) begin
            errors++;
            $display("FAIL stop_partial: wr_ptr=%0d addr0=%h required 0/%h", wr_ptr, rd_data, prev0);
        end
        do_start(0, 4);
        do_stop();
        wait_done(base + 2, "stop_armed");
        checks++;
        if (wr_ptr !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_armed: wr_ptr=%0d busy=%b required 0/0", wr_ptr, busy);
        end
        do_stop();
        wait_done(base + 2, "stop_idle");
        start = 1'b1; stop = 1'b1; cont = 1'b0; len = (AW+1)'(2);
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL idle_start_stop: busy=%b required 1", busy);
        end
        do_stop();
        wait_done(base + 3, "start_stop");
    endtask

    task automatic test_start_during_capture();
        int base = done_cnt;
        do_start(0, 2);
        for (int i = 0; i < 10; i++) feed(2'($urandom_range(3, 0)), 5);
        start = 1'b1; cont = 1'b1; len = (AW+1)'(8);
        @(negedge clk);
        start = 1'b0;
        for (int i = 10; i < 2 * WW; i++) feed(2'($urandom_range(3, 0)), 5);
        wait_done(base + 1, "restart");
        checks++;
        if (wr_ptr !== AW'(2) || busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_len: wr_ptr=%0d busy=%b required 2/0", wr_ptr, busy);
        end
        check_word(0, "restart");
        check_word(1, "restart");
        for (int i = 0; i < WW; i++) feed(2'($urandom_range(3, 0)), 2);
        settle();
        checks++;
        if (wr_ptr !== AW'(2) || done_cnt !== base + 1) begin
            errors++;
            $display("FAIL restart_idle: wr_ptr=%0d done_cnt=%0d required 2/%0d", wr_ptr, done_cnt, base + 1);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        do_start(0, 4);
        for (int i = 0; i < 10; i++) feed(2'($urandom_range(3, 0)), 5);
        rst = 1'b1;
        adc_clk = 1'b0;
        m_active = 0;
        #1;
        checks++;
        if ({busy, done, wr_ptr, wrapped} !== '0 || rd_data !== '0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b wr_ptr=%0d wrapped=%b rd_data=%h required all 0",
                     busy, done, wr_ptr, wrapped, rd_data);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        base = done_cnt;
        do_start(0, 1);
        for (int i = 0; i < WW; i++) feed(2'($urandom_range(3, 0)), 5);
        wait_done(base + 1, "reset_clean");
        checks++;
        if (wr_ptr !== AW'(1)) begin
            errors++;
            $display("FAIL reset_clean_wr_ptr: got %0d required 1", wr_ptr);
        end
        check_word(0, "reset_clean");
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_readback();
        test_ring();
        test_stop();
        test_start_during_capture();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
